// File: rtl/cpu_defs_pkg.sv
// Shared MEM-stage definitions: sequencer state encoding,
// access size codes and fault cause codes.
package cpu_defs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERR    = 2'd3
  } dmem_state_e;

  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

  function automatic logic is_misaligned(
    input logic       size,
    input logic [1:0] off
  );
    return (size == SIZE_WORD) && (off != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian byte-lane steering for data memory:
// byte enables, store replication and load byte select.
module dmem_lane_align
  import cpu_defs_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              size,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] st_data,
  input  logic [DATA_W-1:0] ld_raw,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] st_lane,
  output logic [DATA_W-1:0] ld_data
);

  logic [7:0] ld_byte;

  always_comb begin
    ld_byte = ld_raw[7:0];
    unique case (off)
      2'd0: ld_byte = ld_raw[7:0];
      2'd1: ld_byte = ld_raw[15:8];
      2'd2: ld_byte = ld_raw[23:16];
      2'd3: ld_byte = ld_raw[31:24];
    endcase
  end

  always_comb begin
    be      = 4'b1111;
    st_lane = st_data;
    ld_data = ld_raw;
    if (size == SIZE_BYTE) begin
      be      = 4'b0001 << off;
      st_lane = {4{st_data[7:0]}};
      ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
    end
  end

endmodule

// File: rtl/datamem_sequencer.sv
// MEM-stage load/store sequencer with pipeline stall and fault pulses.
// Optional ACCESS timeout enabled by defining DMEM_TIMEOUT_EN.
module datamem_sequencer
  import cpu_defs_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_load,
  input  logic              req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              stall,
  output logic              done,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              fault,
  output logic [1:0]        fault_cause
);

  dmem_state_e       state_q, state_d;
  logic              load_q, load_d;
  logic              size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        cause_q, cause_d;

  logic [3:0]        lane_be;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] lane_rdata;

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  dmem_lane_align #(.DATA_W(DATA_W)) u_align (
    .size    (size_q),
    .off     (addr_q[1:0]),
    .st_data (wdata_q),
    .ld_raw  (mem_rdata),
    .be      (lane_be),
    .st_lane (lane_wdata),
    .ld_data (lane_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      load_q  <= 1'b0;
      size_q  <= SIZE_WORD;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cause_q <= FAULT_NONE;
`ifdef DMEM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cause_q <= cause_d;
`ifdef DMEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    load_d      = load_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    cause_d     = cause_q;
`ifdef DMEM_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    mem_en      = 1'b0;
    mem_rw      = 1'b0;
    stall       = 1'b0;
    done        = 1'b0;
    rdata_valid = 1'b0;
    fault       = 1'b0;
    fault_cause = FAULT_NONE;
    unique case (state_q)
      ST_IDLE: begin
        stall = req_valid;
        if (req_valid) begin
          if (is_misaligned(req_size, req_addr[1:0])) begin
            cause_d = FAULT_MISALIGN;
            state_d = ST_ERR;
          end else begin
            load_d  = req_load;
            size_d  = req_size;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            state_d = ST_ACCESS;
`ifdef DMEM_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      ST_ACCESS: begin
        mem_en = 1'b1;
        mem_rw = load_q;
        stall  = 1'b1;
        if (mem_ready) begin
          // Stores leave the last load result visible.
          if (load_q) rdata_d = lane_rdata;
          state_d = ST_DONE;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          cause_d = FAULT_TIMEOUT;
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_DONE: begin
        done        = 1'b1;
        rdata_valid = load_q;
        state_d     = ST_IDLE;
      end
      ST_ERR: begin
        fault       = 1'b1;
        fault_cause = cause_q;
        state_d     = ST_IDLE;
      end
    endcase
  end

  assign mem_be    = mem_en ? lane_be : 4'b0000;
  assign mem_addr  = mem_en ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata = mem_en ? lane_wdata : '0;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_datamem_sequencer.sv
// Directed bench for datamem_sequencer; define DMEM_TIMEOUT_EN
// on both RTL and bench to exercise the timeout path.
module tb_datamem_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_load = 1'b0;
  logic        req_size = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_en, mem_rw, stall, done, rdata_valid, fault;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, rdata;
  logic [1:0]  fault_cause;

  int n_cmp = 0;
  int n_err = 0;
  int cnt;
  logic hit;

  datamem_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_load    (req_load),
    .req_size    (req_size),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .mem_en      (mem_en),
    .mem_rw      (mem_rw),
    .mem_be      (mem_be),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .stall       (stall),
    .done        (done),
    .rdata_valid (rdata_valid),
    .rdata       (rdata),
    .fault       (fault),
    .fault_cause (fault_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic to_neg;
    @(negedge clk);
  endtask

  task automatic to_pos;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_be"}, 32'(mem_be), 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
  endtask

  task automatic issue(input logic ld, input logic sz,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1;
    req_load  = ld;
    req_size  = sz;
    req_addr  = a;
    req_wdata = wd;
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    chk_quiet("rst");
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_cause", 32'(fault_cause), 32'd0);
    to_pos;
    to_pos;
    reset = 1'b0;

    // 1: word load, ready immediately
    issue(1'b1, 1'b0, 32'h100, 32'h0);
    mem_ready = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    to_neg;
    chk("t1_c0_stall", 32'(stall), 32'd1);
    chk("t1_c0_en", 32'(mem_en), 32'd0);
    to_pos;
    req_valid = 1'b0;
    to_neg;
    chk("t1_c1_stall", 32'(stall), 32'd1);
    chk("t1_c1_en", 32'(mem_en), 32'd1);
    chk("t1_c1_rw", 32'(mem_rw), 32'd1);
    chk("t1_c1_be", 32'(mem_be), 32'hF);
    chk("t1_c1_addr", mem_addr, 32'h100);
    to_pos;
    to_neg;
    chk("t1_c2_done", 32'(done), 32'd1);
    chk("t1_c2_rv", 32'(rdata_valid), 32'd1);
    chk("t1_c2_stall", 32'(stall), 32'd0);
    chk("t1_c2_rdata", rdata, 32'hDEADBEEF);
    to_pos;
    to_neg;
    chk("t1_c3_done", 32'(done), 32'd0);
    chk("t1_c3_rdata", rdata, 32'hDEADBEEF);
    to_pos;

    // 2: byte store at 0x103, three wait cycles
    issue(1'b0, 1'b1, 32'h103, 32'h1234565A);
    mem_ready = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) req_valid = 1'b0;
      if (i == 4) mem_ready = 1'b1;
      to_neg;
      if (stall) cnt++;
      if (i == 2) begin
        chk("t2_be", 32'(mem_be), 32'h8);
        chk("t2_wdata", mem_wdata, 32'h5A5A5A5A);
        chk("t2_rw", 32'(mem_rw), 32'd0);
        chk("t2_addr", mem_addr, 32'h100);
        chk("t2_wait_done", 32'(done), 32'd0);
      end
      to_pos;
    end
    to_neg;
    chk("t2_stall_cycles", cnt, 32'd5);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_rv", 32'(rdata_valid), 32'd0);
    chk("t2_stall_done", 32'(stall), 32'd0);
    to_pos;

    // 3: byte load at 0x201
    issue(1'b1, 1'b1, 32'h201, 32'h0);
    mem_rdata = 32'h11223344;
    to_pos;
    req_valid = 1'b0;
    to_neg;
    chk("t3_be", 32'(mem_be), 32'h2);
    chk("t3_addr", mem_addr, 32'h200);
    to_pos;
    to_neg;
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_rv", 32'(rdata_valid), 32'd1);
    chk("t3_rdata", rdata, 32'h00000033);
    to_pos;

    // 4: misaligned word load
    issue(1'b1, 1'b0, 32'h102, 32'h0);
    to_neg;
    chk("t4_c0_stall", 32'(stall), 32'd1);
    chk("t4_c0_en", 32'(mem_en), 32'd0);
    to_pos;
    req_valid = 1'b0;
    to_neg;
    chk("t4_fault", 32'(fault), 32'd1);
    chk("t4_cause", 32'(fault_cause), 32'd1);
    chk("t4_c1_en", 32'(mem_en), 32'd0);
    chk("t4_c1_stall", 32'(stall), 32'd0);
    to_pos;
    to_neg;
    chk("t4_c2_fault", 32'(fault), 32'd0);
    chk("t4_c2_cause", 32'(fault_cause), 32'd0);
    to_pos;

    // 5: memory never ready
    issue(1'b1, 1'b0, 32'h300, 32'h0);
    mem_ready = 1'b0;
    to_pos;
    req_valid = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    cnt = 0;
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      to_neg;
      if (fault) begin
        hit = 1'b1;
        chk("t5_cause", 32'(fault_cause), 32'd2);
        chk("t5_fault_en", 32'(mem_en), 32'd0);
        break;
      end
      if (mem_en) cnt++;
      to_pos;
    end
    chk("t5_fault_seen", 32'(hit), 32'd1);
    chk("t5_access_cycles", cnt, 32'd16);
    to_pos;
    to_neg;
    chk("t5_idle_stall", 32'(stall), 32'd0);
    chk("t5_idle_fault", 32'(fault), 32'd0);
    to_pos;
`else
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      to_neg;
      if (stall && mem_en && !fault) cnt++;
      to_pos;
    end
    chk("t5_stall_held", cnt, 32'd40);
    reset = 1'b1;
    to_pos;
    reset = 1'b0;
`endif

    // 6: async reset in the middle of an access
    issue(1'b1, 1'b0, 32'h400, 32'h0);
    mem_ready = 1'b0;
    to_pos;
    req_valid = 1'b0;
    #2;
    chk("t6_pre_en", 32'(mem_en), 32'd1);
    reset = 1'b1;
    #1;
    chk_quiet("t6_rst");
    chk("t6_rst_rdata", rdata, 32'h0);
    to_pos;
    reset = 1'b0;
    mem_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      to_neg;
      if (done || mem_en || stall) cnt++;
      to_pos;
    end
    chk("t6_no_activity", cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
